// File: rtl/board_row_arbiter.sv
// rtl/board_row_arbiter.sv - board RAM owner arbitrating display row prefetch against game cell access
//
// Purpose:
//   Owns the single-port board RAM (ROWS x COLS cells, address = row*COLS + col).
//   Display row requests have priority over game accesses. A row is streamed into a
//   shadow buffer and then copied to Row in one edge, followed by a row_ready pulse.
//
// Ports:
//   Clk, reset        system clock, synchronous active-high reset
//   disp_req/disp_row display row request (edge-detected) and row number
//   Row               current display row, Row[0] = leftmost cell
//   row_ready         one-cycle pulse after Row has been updated
//   disp_overrun      sticky, a pending display request was overwritten
//   game_*            game cell access: request/we/row/col/wdata in, gnt/rdata/rvalid out
//   mem_*             board RAM: addr/we/wdata out, q in (valid the cycle after the address edge)

module board_row_arbiter #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int CELL_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          disp_req,
    input  logic [7:0]                    disp_row,
    output logic [COLS-1:0][CELL_W-1:0]   Row,
    output logic                          row_ready,
    output logic                          disp_overrun,
    input  logic                          game_req,
    input  logic                          game_we,
    input  logic [7:0]                    game_row,
    input  logic [3:0]                    game_col,
    input  logic [CELL_W-1:0]             game_wdata,
    output logic                          game_gnt,
    output logic [CELL_W-1:0]             game_rdata,
    output logic                          game_rvalid,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [CELL_W-1:0]             mem_wdata,
    input  logic [CELL_W-1:0]             mem_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DISP  = 2'd1;
    localparam logic [1:0] S_DLAST = 2'd2;
    localparam logic [1:0] S_GRD   = 2'd3;

    localparam logic [7:0]        ROWS_L   = 8'(ROWS);
    localparam logic [3:0]        COLS_L   = 4'(COLS);
    localparam logic [3:0]        LAST_COL = 4'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    logic [1:0]        state;
    logic              disp_req_q;
    logic              pending;
    logic [7:0]        pend_row;
    logic [3:0]        col;
    logic [ADDR_W-1:0] base;
    logic [CELL_W-1:0] shadow [COLS];
    logic              grd_oor;

    logic              disp_rise;
    logic              pending_eff;
    logic [7:0]        sel_row;
    logic [ADDR_W-1:0] sel_base;
    logic              accept;
    logic              game_oor;
    logic [ADDR_W-1:0] game_addr;

    // A rising edge in the accepting cycle is served directly instead of being pended,
    // so the display still wins against a game request arriving in the same cycle.
    assign disp_rise   = disp_req & ~disp_req_q;
    assign pending_eff = pending | disp_rise;
    assign sel_row     = disp_rise ? disp_row : pend_row;
    assign accept      = (state == S_IDLE) && pending_eff;

    // Rows past the bottom of the board wrap to row 0 (end-of-frame request).
    assign sel_base = (sel_row >= ROWS_L) ? '0 : ADDR_W'(sel_row) * COLS_A;

    assign game_oor  = (game_row >= ROWS_L) || (game_col >= COLS_L);
    assign game_addr = game_oor ? '0 : ADDR_W'(game_row) * COLS_A + ADDR_W'(game_col);

    assign game_gnt = !reset && (state == S_IDLE) && !pending_eff && game_req;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = game_wdata;
        if (game_gnt) begin
            mem_addr = game_addr;
            mem_we   = game_we && !game_oor;
        end else if (state == S_DISP) begin
            mem_addr = base + ADDR_W'(col);
        end
    end

    always_ff @(posedge Clk) begin
        disp_req_q <= disp_req;
        if (reset) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            pend_row     <= '0;
            disp_overrun <= 1'b0;
            col          <= '0;
            base         <= '0;
            grd_oor      <= 1'b0;
            Row          <= '0;
            row_ready    <= 1'b0;
            game_rdata   <= '0;
            game_rvalid  <= 1'b0;
        end else begin
            row_ready   <= 1'b0;
            game_rvalid <= 1'b0;

            // Request capture outside IDLE; in IDLE any request is accepted this edge.
            if (state == S_IDLE) begin
                if (disp_rise && pending) begin
                    disp_overrun <= 1'b1;
                end
            end else if (disp_rise) begin
                pending  <= 1'b1;
                pend_row <= disp_row;
                if (pending) begin
                    disp_overrun <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_DISP;
                        col     <= '0;
                        base    <= sel_base;
                        pending <= 1'b0;
                    end else if (game_gnt && !game_we) begin
                        state   <= S_GRD;
                        grd_oor <= game_oor;
                    end
                end
                S_DISP: begin
                    // RAM data lags the issued column by one cycle.
                    if (col != 4'd0) begin
                        shadow[col - 4'd1] <= mem_q;
                    end
                    col <= col + 4'd1;
                    if (col == LAST_COL) begin
                        state <= S_DLAST;
                    end
                end
                S_DLAST: begin
                    // Last cell bypasses the shadow so the whole row lands in one edge.
                    shadow[COLS-1] <= mem_q;
                    for (int i = 0; i < COLS - 1; i++) begin
                        Row[i] <= shadow[i];
                    end
                    Row[COLS-1] <= mem_q;
                    row_ready   <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    game_rdata  <= grd_oor ? '0 : mem_q;
                    game_rvalid <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_row_arbiter.sv
// tb/tb_board_row_arbiter.sv - scoreboard bench for board_row_arbiter

module tb_board_row_arbiter;

    localparam int COLS   = 10;
    localparam int CELL_W = 16;
    localparam int ADDR_W = 8;

    typedef logic [COLS*CELL_W-1:0] row_t;

    logic                        Clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        disp_req = 1'b0;
    logic [7:0]                  disp_row = '0;
    logic [COLS-1:0][CELL_W-1:0] Row;
    logic                        row_ready;
    logic                        disp_overrun;
    logic                        game_req = 1'b0;
    logic                        game_we = 1'b0;
    logic [7:0]                  game_row = '0;
    logic [3:0]                  game_col = '0;
    logic [CELL_W-1:0]           game_wdata = '0;
    logic                        game_gnt;
    logic [CELL_W-1:0]           game_rdata;
    logic                        game_rvalid;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_we;
    logic [CELL_W-1:0]           mem_wdata;
    logic [CELL_W-1:0]           mem_q;

    always #5 Clk = ~Clk;

    board_row_arbiter dut (
        .Clk          (Clk),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_row     (disp_row),
        .Row          (Row),
        .row_ready    (row_ready),
        .disp_overrun (disp_overrun),
        .game_req     (game_req),
        .game_we      (game_we),
        .game_row     (game_row),
        .game_col     (game_col),
        .game_wdata   (game_wdata),
        .game_gnt     (game_gnt),
        .game_rdata   (game_rdata),
        .game_rvalid  (game_rvalid),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_q        (mem_q)
    );

    // Board RAM model, preloaded so cell (r,c) holds {r, c} as bytes.
    logic [CELL_W-1:0] ram [256];
    logic [ADDR_W-1:0] addr_q = '0;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < COLS; c++)
                ram[r*COLS + c] = 16'((r << 8) | c);
    end

    always @(posedge Clk) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        addr_q <= mem_addr;
    end

    assign mem_q = ram[addr_q];

    int n_chk  = 0;
    int n_pass = 0;

    row_t              row_q [$];
    logic [CELL_W-1:0] rd_q [$];
    row_t              last_exp = '0;
    row_t              mon_row;
    logic [CELL_W-1:0] mon_rd;

    task automatic chk(input string name, input row_t got, input row_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic row_t exp_row(input int r);
        row_t e;
        for (int c = 0; c < COLS; c++) e[c*CELL_W +: CELL_W] = 16'((r << 8) | c);
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a row or read data.
    always @(negedge Clk) begin
        if (row_ready) begin
            if (row_q.size() == 0) chk("row_ready_unexpected", 1, 0);
            else begin
                mon_row = row_q.pop_front();
                chk("row_data", Row, mon_row);
            end
        end
        if (game_rvalid) begin
            if (rd_q.size() == 0) chk("rvalid_unexpected", 1, 0);
            else begin
                mon_rd = rd_q.pop_front();
                chk("game_rdata", game_rdata, mon_rd);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic game_access(input logic we, input logic [7:0] r, input logic [3:0] c,
                               input logic [15:0] wd, output int wt, output logic we_seen);
        step();
        game_req = 1'b1; game_we = we; game_row = r; game_col = c; game_wdata = wd;
        wt = -1;
        we_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (game_gnt) begin
                wt = k;
                we_seen = mem_we;
                break;
            end
        end
        step();
        game_req = 1'b0; game_we = 1'b0;
    endtask

    task automatic game_read(input logic [7:0] r, input logic [3:0] c,
                             input logic [15:0] exp, input string tag);
        int wt;
        logic ws;
        int lat;
        rd_q.push_back(exp);
        game_access(1'b0, r, c, 16'h0, wt, ws);
        chk({tag, "_wait"}, wt, 0);
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            if (game_rvalid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 2);
    endtask

    task automatic fetch(input logic [7:0] r, input int er, input string tag);
        row_t e;
        int   lat;
        logic early;
        e = exp_row(er);
        row_q.push_back(e);
        step();
        disp_row = r;
        disp_req = 1'b1;
        step();
        disp_req = 1'b0;
        lat = -1;
        early = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            @(negedge Clk);
            if (row_ready) begin
                lat = k;
                break;
            end
            if (Row !== last_exp) early = 1'b1;
        end
        chk({tag, "_latency"}, lat, 11);
        chk({tag, "_row_stable"}, early, 0);
        @(negedge Clk);
        chk({tag, "_pulse_width"}, row_ready, 0);
        last_exp = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   wt;
        int   low;
        int   pulses;
        logic ws;
        logic seen;

        game_req = 1'b1; game_we = 1'b1; game_row = 8'd1; game_col = 4'd1; game_wdata = 16'h1234;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_gnt", game_gnt, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_row", Row, 0);
        chk("reset_row_ready", row_ready, 0);
        chk("reset_rvalid", game_rvalid, 0);
        chk("reset_rdata", game_rdata, 0);
        chk("reset_overrun", disp_overrun, 0);
        step();
        reset = 1'b0; game_req = 1'b0; game_we = 1'b0;

        fetch(8'd3, 3, "fetch_r3");
        fetch(8'd20, 0, "wrap_20");
        fetch(8'd255, 0, "wrap_255");

        step();
        row_q.push_back(exp_row(7));
        disp_row = 8'd7; disp_req = 1'b1;
        game_req = 1'b1; game_we = 1'b1; game_row = 8'd5; game_col = 4'd2; game_wdata = 16'h0ABC;
        low = -1;
        ws = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (game_gnt) begin
                low = k;
                ws = mem_we;
                break;
            end
        end
        chk("simul_gnt_low_cycles", low, 12);
        chk("simul_write_we", ws, 1);
        step();
        game_req = 1'b0; game_we = 1'b0; disp_req = 1'b0;
        last_exp = exp_row(7);

        game_read(8'd5, 4'd2, 16'h0ABC, "read_5_2");
        game_read(8'd1, 4'd1, 16'h0101, "read_1_1");

        chk("overrun_clear", disp_overrun, 0);
        step();
        row_q.push_back(exp_row(1));
        row_q.push_back(exp_row(6));
        disp_row = 8'd1; disp_req = 1'b1;
        step();
        disp_req = 1'b0;
        step();
        step();
        disp_row = 8'd4; disp_req = 1'b1;
        step();
        disp_req = 1'b0;
        @(negedge Clk);
        chk("overrun_first_req", disp_overrun, 0);
        step();
        disp_row = 8'd6; disp_req = 1'b1;
        step();
        disp_req = 1'b0;
        @(negedge Clk);
        chk("overrun_set", disp_overrun, 1);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (row_ready) pulses++;
        end
        chk("overrun_fetch_count", pulses, 2);
        chk("overrun_sticky", disp_overrun, 1);

        step();
        disp_row = 8'd2; disp_req = 1'b1;
        step();
        disp_req = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (row_ready) seen = 1'b1;
        end
        chk("mid_reset_no_ready", seen, 0);
        chk("mid_reset_row", Row, 0);
        chk("mid_reset_overrun", disp_overrun, 0);
        last_exp = '0;
        game_read(8'd3, 4'd4, 16'h0304, "post_reset_read");

        game_access(1'b1, 8'd0, 4'd12, 16'hFFFF, wt, ws);
        chk("oor_write_wait", wt, 0);
        chk("oor_write_we", ws, 0);
        game_read(8'd25, 4'd0, 16'h0000, "oor_read");
        game_read(8'd1, 4'd2, 16'h0102, "read_1_2_intact");

        fetch(8'd19, 19, "fetch_r19");

        repeat (3) step();
        chk("row_queue_empty", row_q.size(), 0);
        chk("rd_queue_empty", rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
